// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard sequencer: stalls for EX/MEM producers, selects comparator
// forwarding, drives PC redirect/flush on taken branches, and keeps saturating perf counters.
module branch_hazard_ctrl #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              id_branch,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [4:0]        mem_rd,
  input  logic              take_branch,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              pc_sel,
  output logic              flush_if_id,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [PERF_W-1:0] branch_cnt,
  output logic [PERF_W-1:0] taken_cnt,
  output logic [PERF_W-1:0] stall_cyc_cnt
);

  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

  localparam logic [PERF_W-1:0] ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  state_t     state_r, state_s;
  logic [1:0] cnt_r, cnt_s;
  logic [4:0] wb_rd_r;
  logic       wb_reg_write_r;
  logic       resolve_s;
  logic       stall_s;

  function automatic logic reg_match(input logic we, input logic [4:0] rd, input logic [4:0] rs);
    return we && (rd == rs) && (rd != 5'd0);
  endfunction

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : (v + ONE);
  endfunction

  logic       ex_m1_s, ex_m2_s, mem_m1_s, mem_m2_s, wb_m1_s, wb_m2_s;
  logic [1:0] need1_s, need2_s, need_s;

  assign ex_m1_s  = reg_match(ex_reg_write, ex_rd, id_rs1);
  assign ex_m2_s  = reg_match(ex_reg_write, ex_rd, id_rs2);
  assign mem_m1_s = reg_match(mem_reg_write, mem_rd, id_rs1);
  assign mem_m2_s = reg_match(mem_reg_write, mem_rd, id_rs2);
  assign wb_m1_s  = reg_match(wb_reg_write_r, wb_rd_r, id_rs1);
  assign wb_m2_s  = reg_match(wb_reg_write_r, wb_rd_r, id_rs2);

  // A load in EX needs two cycles to reach a forwardable stage; ALU results in EX or loads in MEM need one.
  assign need1_s = (ex_m1_s && ex_mem_read) ? 2'd2 :
                   (ex_m1_s || (mem_m1_s && mem_mem_read)) ? 2'd1 : 2'd0;
  assign need2_s = (ex_m2_s && ex_mem_read) ? 2'd2 :
                   (ex_m2_s || (mem_m2_s && mem_mem_read)) ? 2'd1 : 2'd0;
  assign need_s  = (need1_s > need2_s) ? need1_s : need2_s;

  assign fwd_a_sel = (mem_m1_s && !mem_mem_read) ? 2'b01 : (wb_m1_s ? 2'b10 : 2'b00);
  assign fwd_b_sel = (mem_m2_s && !mem_mem_read) ? 2'b01 : (wb_m2_s ? 2'b10 : 2'b00);

  // Next-state and Mealy control outputs; hold freezes sequencing and suppresses bubble/redirect.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    resolve_s = 1'b0;
    stall_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (id_branch) begin
          if (need_s != 2'd0) begin
            stall_s = 1'b1;
            if (!hold) begin
              state_s = STALL;
              cnt_s   = need_s - 2'd1;
            end else begin
              state_s = IDLE;
            end
          end else begin
            resolve_s = !hold;
          end
        end else begin
          state_s = IDLE;
        end
      end
      STALL: begin
        stall_s = 1'b1;
        if (!hold) begin
          if (cnt_r != 2'd0) begin
            cnt_s = cnt_r - 2'd1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = STALL;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 2'd0;
      end
    endcase
  end

  assign stall_pc     = stall_s | hold;
  assign stall_if_id  = stall_s | hold;
  assign bubble_id_ex = stall_s & ~hold;
  assign pc_sel       = resolve_s & take_branch;
  assign flush_if_id  = resolve_s & take_branch;

  // FSM state, stall countdown and MEM/WB shadow of the MEM-stage destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      cnt_r          <= 2'd0;
      wb_rd_r        <= 5'd0;
      wb_reg_write_r <= 1'b0;
    end else if (!hold) begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      wb_rd_r        <= mem_rd;
      wb_reg_write_r <= mem_reg_write;
    end else begin
      state_r        <= state_r;
      cnt_r          <= cnt_r;
      wb_rd_r        <= wb_rd_r;
      wb_reg_write_r <= wb_reg_write_r;
    end
  end

  // Saturating performance counters, frozen while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt    <= '0;
      taken_cnt     <= '0;
      stall_cyc_cnt <= '0;
    end else if (!hold) begin
      if (resolve_s) begin
        branch_cnt <= sat_inc(branch_cnt);
      end
      if (resolve_s && take_branch) begin
        taken_cnt <= sat_inc(taken_cnt);
      end
      if (state_r == STALL) begin
        stall_cyc_cnt <= sat_inc(stall_cyc_cnt);
      end
    end else begin
      branch_cnt    <= branch_cnt;
      taken_cnt     <= taken_cnt;
      stall_cyc_cnt <= stall_cyc_cnt;
    end
  end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl; narrow counters (PERF_W=3) make saturation reachable.
module tb_branch_hazard_ctrl;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n, hold, id_branch, ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read, take_branch;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic stall_pc, stall_if_id, bubble_id_ex, pc_sel, flush_if_id;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [W-1:0] branch_cnt, taken_cnt, stall_cyc_cnt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(.PERF_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .id_branch(id_branch),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .take_branch(take_branch),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex),
    .pc_sel(pc_sel), .flush_if_id(flush_if_id),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt), .stall_cyc_cnt(stall_cyc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic set_ex(input logic we, input logic ld, input logic [4:0] rd);
    ex_reg_write = we; ex_mem_read = ld; ex_rd = rd;
  endtask

  task automatic set_mem(input logic we, input logic ld, input logic [4:0] rd);
    mem_reg_write = we; mem_mem_read = ld; mem_rd = rd;
  endtask

  task automatic set_br(input logic br, input logic [4:0] rs1, input logic [4:0] rs2, input logic tk);
    id_branch = br; id_rs1 = rs1; id_rs2 = rs2; take_branch = tk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic st, input logic bub, input logic pcs);
    chk({tag, "_stall_pc"}, {31'd0, stall_pc}, {31'd0, st});
    chk({tag, "_stall_if_id"}, {31'd0, stall_if_id}, {31'd0, st});
    chk({tag, "_bubble"}, {31'd0, bubble_id_ex}, {31'd0, bub});
    chk({tag, "_pc_sel"}, {31'd0, pc_sel}, {31'd0, pcs});
    chk({tag, "_flush"}, {31'd0, flush_if_id}, {31'd0, pcs});
  endtask

  task automatic chk_cnt(input string tag, input int b, input int t, input int s);
    chk({tag, "_branch_cnt"}, {29'd0, branch_cnt}, b);
    chk({tag, "_taken_cnt"}, {29'd0, taken_cnt}, t);
    chk({tag, "_stall_cyc_cnt"}, {29'd0, stall_cyc_cnt}, s);
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    set_ex(1'b0, 1'b0, 5'd0); set_mem(1'b0, 1'b0, 5'd0); set_br(1'b0, 5'd0, 5'd0, 1'b0);
    #3;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk_cnt("reset", 0, 0, 0);
    chk("reset_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // 1: no hazard, taken -> same-cycle redirect
    tick(); set_br(1'b1, 5'd1, 5'd2, 1'b1); #1;
    chk_ctl("t1_resolve", 1'b0, 1'b0, 1'b1);
    tick(); set_br(1'b0, 5'd0, 5'd0, 1'b0); #1;
    chk_cnt("t1_after", 1, 1, 0);
    chk_ctl("t1_idle", 1'b0, 1'b0, 1'b0);

    // 2: ALU write x5 in EX, branch on rs1=x5 -> one STALL cycle, then forward from EX/MEM
    set_ex(1'b1, 1'b0, 5'd5); set_br(1'b1, 5'd5, 5'd0, 1'b1); #1;
    chk_ctl("t2_detect", 1'b1, 1'b1, 1'b0);
    tick(); set_ex(1'b0, 1'b0, 5'd0); set_mem(1'b1, 1'b0, 5'd5); #1;
    chk_ctl("t2_stall", 1'b1, 1'b1, 1'b0);
    tick(); #1;
    chk_ctl("t2_resolve", 1'b0, 1'b0, 1'b1);
    chk("t2_fwd_a", {30'd0, fwd_a_sel}, 32'd1);
    chk_cnt("t2_mid", 1, 1, 1);
    tick(); set_br(1'b0, 5'd0, 5'd0, 1'b0); set_mem(1'b0, 1'b0, 5'd0); #1;
    chk_cnt("t2_after", 2, 2, 1);

    // 3: load x6 in EX, branch on rs2=x6 -> two STALL cycles, forward from MEM/WB, not taken
    tick(); set_ex(1'b1, 1'b1, 5'd6); set_br(1'b1, 5'd0, 5'd6, 1'b0); #1;
    chk_ctl("t3_detect", 1'b1, 1'b1, 1'b0);
    tick(); set_ex(1'b0, 1'b0, 5'd0); set_mem(1'b1, 1'b1, 5'd6); #1;
    chk_ctl("t3_stall1", 1'b1, 1'b1, 1'b0);
    chk("t3_fwd_b_load_mem", {30'd0, fwd_b_sel}, 32'd0);
    tick(); #1;
    chk_ctl("t3_stall2", 1'b1, 1'b1, 1'b0);
    tick(); set_mem(1'b0, 1'b0, 5'd0); #1;
    chk_ctl("t3_resolve", 1'b0, 1'b0, 1'b0);
    chk("t3_fwd_b", {30'd0, fwd_b_sel}, 32'd2);
    tick(); set_br(1'b0, 5'd0, 5'd0, 1'b0); #1;
    chk_cnt("t3_after", 3, 2, 3);

    // 4: same as 3 with hold asserted for three cycles inside STALL
    set_ex(1'b1, 1'b1, 5'd6); set_br(1'b1, 5'd0, 5'd6, 1'b0); #1;
    chk_ctl("t4_detect", 1'b1, 1'b1, 1'b0);
    tick(); set_ex(1'b0, 1'b0, 5'd0); set_mem(1'b1, 1'b1, 5'd6); hold = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk_ctl("t4_held", 1'b1, 1'b0, 1'b0);
      chk("t4_held_stall_cyc", {29'd0, stall_cyc_cnt}, 32'd3);
      tick();
    end
    hold = 1'b0; #1;
    chk_ctl("t4_stall1", 1'b1, 1'b1, 1'b0);
    tick(); #1;
    chk_ctl("t4_stall2", 1'b1, 1'b1, 1'b0);
    chk("t4_stall_cyc_mid", {29'd0, stall_cyc_cnt}, 32'd4);
    tick(); set_mem(1'b0, 1'b0, 5'd0); #1;
    chk_ctl("t4_resolve", 1'b0, 1'b0, 1'b0);
    chk("t4_fwd_b", {30'd0, fwd_b_sel}, 32'd2);
    tick(); set_br(1'b0, 5'd0, 5'd0, 1'b0); #1;
    chk_cnt("t4_after", 4, 2, 5);

    // 4b: hold on a would-be resolve cycle blocks redirect and counting
    set_br(1'b1, 5'd1, 5'd2, 1'b1); hold = 1'b1; #1;
    chk_ctl("t4b_held", 1'b1, 1'b0, 1'b0);
    tick(); hold = 1'b0; #1;
    chk_cnt("t4b_held_cnt", 4, 2, 5);
    chk_ctl("t4b_resolve", 1'b0, 1'b0, 1'b1);
    tick(); set_br(1'b0, 5'd0, 5'd0, 1'b0); #1;
    chk_cnt("t4b_after", 5, 3, 5);

    // 5: x0 never matches
    set_ex(1'b1, 1'b0, 5'd0); set_br(1'b1, 5'd0, 5'd0, 1'b1); #1;
    chk_ctl("t5_x0", 1'b0, 1'b0, 1'b1);
    chk("t5_fwd_a", {30'd0, fwd_a_sel}, 32'd0);
    tick(); set_ex(1'b0, 1'b0, 5'd0); #1;
    chk_cnt("t5_after", 6, 4, 5);

    // saturation: four more taken resolves push both counters past 7
    for (int i = 0; i < 4; i++) tick();
    set_br(1'b0, 5'd0, 5'd0, 1'b0); #1;
    chk_cnt("sat", 7, 7, 5);

    // 6: reset asserted mid-STALL
    set_ex(1'b1, 1'b0, 5'd5); set_br(1'b1, 5'd5, 5'd0, 1'b0);
    tick(); #1;
    chk_ctl("t6_stall", 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0; set_ex(1'b0, 1'b0, 5'd0); set_br(1'b0, 5'd0, 5'd0, 1'b0); #1;
    chk_ctl("t6_reset", 1'b0, 1'b0, 1'b0);
    chk_cnt("t6_reset", 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    tick(); set_br(1'b1, 5'd1, 5'd2, 1'b1); #1;
    chk_ctl("t6_idle_resolve", 1'b0, 1'b0, 1'b1);
    tick(); set_br(1'b0, 5'd0, 5'd0, 1'b0); #1;
    chk_cnt("t6_after", 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
